// File: rtl/lock_sequencer.sv
// lock_sequencer: automatic operator for the canal lock controller.
// Walks one gondola through equalise, open, wait and close on each side.
module lock_sequencer #(
  parameter int TOL         = 1,
  parameter int DOOR_CYCLES = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_arrive,
  input  logic       req_depart,
  input  logic [7:0] inner_water,
  input  logic [7:0] lock_water,
  input  logic [7:0] outer_water,
  input  logic       gondola_in_lock,
  output logic [6:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [3:0] {
    IDLE,
    EQ_SRC,
    OPEN_SRC,
    WAIT_ENTER,
    CLOSE_SRC,
    EQ_DST,
    OPEN_DST,
    WAIT_EXIT,
    CLOSE_DST,
    FAULT
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  state_t        state_n;
  logic          arr;
  logic          arr_n;
  logic          last_arr;
  logic          last_n;
  logic [CW-1:0] cnt;
  logic [6:0]    cmd_n;
  logic          busy_n;
  logic          done_n;
  logic          fault_n;
  logic          door_up;
  logic          timed_out;
  logic [7:0]    src_lvl;
  logic [7:0]    dst_lvl;
  logic [7:0]    src_n;
  logic [7:0]    dst_n;

  // {raise, lower}; 9-bit band so target +/- TOL never wraps
  function automatic logic [1:0] trim(
    input logic [7:0] lvl,
    input logic [7:0] tgt
  );
    logic [8:0] t9;
    logic [8:0] tol9;
    logic [8:0] lo;
    logic [8:0] hi;
    t9   = {1'b0, tgt};
    tol9 = 9'(TOL);
    lo   = (t9 < tol9) ? 9'd0 : t9 - tol9;
    hi   = t9 + tol9;
    if (hi > 9'd255) hi = 9'd255;
    trim = {({1'b0, lvl} < lo), ({1'b0, lvl} > hi)};
  endfunction

  assign src_lvl   = arr ? outer_water : inner_water;
  assign dst_lvl   = arr ? inner_water : outer_water;
  assign door_up   = int'(cnt) + 1 >= DOOR_CYCLES;
  assign timed_out = int'(cnt) + 1 >= TIMEOUT;

  always_comb begin
    state_n = state;
    arr_n   = arr;
    last_n  = last_arr;
    unique case (state)
      IDLE: begin
        if (req_arrive || req_depart) begin
          arr_n   = (req_arrive && req_depart) ? !last_arr
                                               : req_arrive;
          last_n  = arr_n;
          state_n = EQ_SRC;
        end
      end
      EQ_SRC: begin
        if (trim(lock_water, src_lvl) == 2'b00)
          state_n = OPEN_SRC;
      end
      OPEN_SRC: begin
        if (door_up) state_n = WAIT_ENTER;
      end
      WAIT_ENTER: begin
        if (gondola_in_lock) state_n = CLOSE_SRC;
      end
      CLOSE_SRC: state_n = EQ_DST;
      EQ_DST: begin
        if (trim(lock_water, dst_lvl) == 2'b00)
          state_n = OPEN_DST;
      end
      OPEN_DST: begin
        if (door_up) state_n = WAIT_EXIT;
      end
      WAIT_EXIT: begin
        if (!gondola_in_lock) state_n = CLOSE_DST;
      end
      CLOSE_DST: state_n = IDLE;
      FAULT:     state_n = FAULT;
      default:   state_n = IDLE;
    endcase
    if (state != IDLE && state != FAULT && timed_out)
      state_n = FAULT;
  end

  // Outputs are decoded from the state being entered, then registered
  assign src_n = arr_n ? outer_water : inner_water;
  assign dst_n = arr_n ? inner_water : outer_water;

  always_comb begin
    cmd_n = '0;
    unique case (state_n)
      EQ_SRC:   cmd_n[2:1] = trim(lock_water, src_n);
      OPEN_SRC: cmd_n[4:3] = arr_n ? 2'b10 : 2'b01;
      WAIT_ENTER: begin
        cmd_n[4:3] = arr_n ? 2'b10 : 2'b01;
        cmd_n[6:5] = arr_n ? 2'b10 : 2'b01;
      end
      EQ_DST:   cmd_n[2:1] = trim(lock_water, dst_n);
      OPEN_DST, WAIT_EXIT:
        cmd_n[4:3] = arr_n ? 2'b01 : 2'b10;
      default:  cmd_n = '0;
    endcase
  end

  assign busy_n  = (state_n != IDLE) && (state_n != FAULT);
  assign done_n  = (state_n == CLOSE_DST);
  assign fault_n = (state_n == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      arr      <= 1'b0;
      last_arr <= 1'b0;
      cnt      <= '0;
      cmd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      arr      <= arr_n;
      last_arr <= last_n;
      if (state_n != state) cnt <= '0;
      else if (!(&cnt))     cnt <= cnt + 1'b1;
      cmd      <= cmd_n;
      busy     <= busy_n;
      done     <= done_n;
      fault    <= fault_n;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed plus random transits against a
// phase-table reference model of the lock sequencer.
module tb_lock_sequencer;

  localparam int TOL  = 1;
  localparam int DOOR = 4;
  localparam int TMO  = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_arrive = 1'b0;
  logic       req_depart = 1'b0;
  logic [7:0] inner_water = 8'd20;
  logic [7:0] lock_water  = 8'd2;
  logic [7:0] outer_water = 8'd10;
  logic       gondola_in_lock = 1'b0;
  logic [6:0] cmd;
  logic       busy;
  logic       done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lock_sequencer #(
    .TOL(TOL), .DOOR_CYCLES(DOOR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_arrive(req_arrive), .req_depart(req_depart),
    .inner_water(inner_water), .lock_water(lock_water),
    .outer_water(outer_water),
    .gondola_in_lock(gondola_in_lock),
    .cmd(cmd), .busy(busy), .done(done), .fault(fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1..4 source side (eq, open, wait, close),
  // 5..8 destination side (same order), 9 fault.
  localparam int K_IDLE = 0, K_EQ = 1, K_OPEN = 2;
  localparam int K_WAIT = 3, K_CLOSE = 4, K_FLT = 5;
  int kind [0:9] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 5};

  int   mp = 0;
  int   mdw = 0;
  bit   marr = 0;
  bit   mlast = 0;
  bit   mvalid = 0;
  logic [6:0] ecmd = '0;
  bit   ebusy = 0;
  bit   edone = 0;
  bit   efault = 0;

  // +1 chamber must rise, -1 must fall, 0 is level
  function automatic int trend(input int lvl, input int tgt);
    int lo;
    int hi;
    lo = tgt - TOL;
    hi = tgt + TOL;
    if (lo < 0) lo = 0;
    if (hi > 255) hi = 255;
    if (lvl < lo) return 1;
    if (lvl > hi) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int  np;
    int  k;
    int  tr;
    bit  outer_side;
    if (rst) begin
      mp = 0; mdw = 0; marr = 0; mlast = 0;
    end else begin
      np = mp;
      k  = kind[mp];
      outer_side = marr ^ (mp >= 5);
      tr = trend(int'(lock_water),
                 outer_side ? int'(outer_water) : int'(inner_water));
      if (k == K_IDLE && (req_arrive || req_depart)) begin
        marr  = (req_arrive && req_depart) ? !mlast : req_arrive;
        mlast = marr;
        np    = 1;
      end else if (k == K_EQ && tr == 0) np = mp + 1;
      else if (k == K_OPEN && mdw + 1 >= DOOR) np = mp + 1;
      else if (k == K_WAIT && gondola_in_lock == (mp < 5)) np = mp + 1;
      else if (k == K_CLOSE) np = (mp == 8) ? 0 : mp + 1;
      if (k != K_IDLE && k != K_FLT && mdw + 1 >= TMO) np = 9;
      mdw = (np == mp) ? mdw + 1 : 0;
      mp  = np;
    end
    k = kind[mp];
    outer_side = marr ^ (mp >= 5);
    ecmd = '0;
    if (k == K_EQ) begin
      tr = trend(int'(lock_water),
                 outer_side ? int'(outer_water) : int'(inner_water));
      ecmd[2] = (tr > 0);
      ecmd[1] = (tr < 0);
    end
    if (k == K_OPEN || k == K_WAIT)
      ecmd = outer_side ? 7'h10 : 7'h08;
    if (k == K_WAIT && mp < 5)
      ecmd = ecmd | (marr ? 7'h40 : 7'h20);
    ebusy  = (k != K_IDLE) && (k != K_FLT);
    edone  = (mp == 8);
    efault = (k == K_FLT);
    mvalid = 1;
  end

  always @(negedge clk) begin
    bit inv;
    if (mvalid) begin
      chk("cmd", int'(cmd), int'(ecmd));
      chk("busy", int'(busy), int'(ebusy));
      chk("done", int'(done), int'(edone));
      chk("fault", int'(fault), int'(efault));
      inv = !(cmd[4] && cmd[3]) && !(cmd[2] && cmd[1]) &&
            !((cmd[2] || cmd[1]) && (cmd[4] || cmd[3])) && !cmd[0];
      chk("invariants", int'(inv), 1);
    end
  end

  // ---------------- environment: water and gondola ----------------
  bit env_auto = 1;
  int enter_dly = 3;
  int exit_dly = 2;
  int env_cnt = 0;

  always @(negedge clk) begin
    int up;
    int dn;
    int lw;
    up = (inner_water > outer_water) ? int'(inner_water) : int'(outer_water);
    dn = (inner_water > outer_water) ? int'(outer_water) : int'(inner_water);
    lw = int'(lock_water);
    if (cmd[2] && up > lw) lock_water = 8'(lw + (up - lw + 1) / 2);
    if (cmd[1] && lw > dn) lock_water = 8'(lw - (lw - dn + 1) / 2);
    if (env_auto && (cmd[6] || cmd[5]) && !gondola_in_lock) begin
      env_cnt++;
      if (env_cnt >= enter_dly) begin
        gondola_in_lock = 1'b1;
        env_cnt = 0;
      end
    end else if (env_auto && gondola_in_lock && (cmd[4] || cmd[3]) &&
                 !(cmd[6] || cmd[5])) begin
      env_cnt++;
      if (env_cnt >= exit_dly) begin
        gondola_in_lock = 1'b0;
        env_cnt = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  int n_oo, n_oi, n_rs, n_lw, n_arr, n_dep, lock_enter;

  task automatic run_transit(input int maxc, output bit ok);
    ok = 0;
    n_oo = 0; n_oi = 0; n_rs = 0; n_lw = 0;
    n_arr = 0; n_dep = 0; lock_enter = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      n_oo += int'(cmd[4]);
      n_oi += int'(cmd[3]);
      n_rs += int'(cmd[2]);
      n_lw += int'(cmd[1]);
      n_arr += int'(cmd[6]);
      n_dep += int'(cmd[5]);
      if ((cmd[6] || cmd[5]) && lock_enter < 0)
        lock_enter = int'(lock_water);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    gondola_in_lock = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int dir_of();
    if (n_arr > 0 && n_dep == 0) return 1;
    if (n_dep > 0 && n_arr == 0) return 2;
    return 0;
  endfunction

  initial begin
    bit ok;
    bit found;
    int n;
    int busy_seen;

    // reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    rst = 1'b0;

    // arrival: outer 10, lock 2, inner 20
    req_arrive = 1'b1;
    @(negedge clk);
    chk("arr_first_raise", int'(cmd), 'h04);
    req_arrive = 1'b0;
    run_transit(200, ok);
    chk("arr_completes", int'(ok), 1);
    chk("arr_open_outer_cycles", n_oo, DOOR + 3);
    chk("arr_src_level", int'(lock_enter >= 9 && lock_enter <= 11), 1);
    chk("arr_dst_level", int'(lock_water >= 19), 1);
    chk("arr_inner_opened", int'(n_oi > 0), 1);
    chk("arr_dir", dir_of(), 1);
    @(negedge clk);
    chk("arr_after_cmd", int'(cmd), 0);
    chk("arr_after_done", int'(done), 0);

    // departure: inner 20, lock 20, outer 10
    lock_water = 8'd20;
    req_depart = 1'b1;
    @(negedge clk);
    chk("dep_eq_src_cmd", int'(cmd), 0);
    chk("dep_eq_src_busy", int'(busy), 1);
    req_depart = 1'b0;
    @(negedge clk);
    chk("dep_open_inner", int'(cmd), 'h08);
    run_transit(200, ok);
    chk("dep_completes", int'(ok), 1);
    chk("dep_cmd5_cycles", n_dep, 3);
    chk("dep_lowered", int'(n_lw > 0), 1);
    chk("dep_dst_level",
        int'(lock_water >= 9 && lock_water <= 11), 1);

    // simultaneous requests from reset
    pulse_rst();
    req_arrive = 1'b1;
    req_depart = 1'b1;
    run_transit(200, ok);
    chk("tie1_done", int'(ok), 1);
    chk("tie1_dir", dir_of(), 1);
    run_transit(200, ok);
    chk("tie2_done", int'(ok), 1);
    chk("tie2_dir", dir_of(), 2);
    run_transit(200, ok);
    req_arrive = 1'b0;
    req_depart = 1'b0;
    chk("tie3_done", int'(ok), 1);
    chk("tie3_dir", dir_of(), 1);
    @(negedge clk);

    // boundary levels
    inner_water = 8'd255;
    outer_water = 8'd0;
    lock_water  = 8'd128;
    req_arrive  = 1'b1;
    @(negedge clk);
    req_arrive  = 1'b0;
    run_transit(300, ok);
    chk("bnd_completes", int'(ok), 1);
    chk("bnd_src_low", int'(lock_enter >= 0 && lock_enter <= 1), 1);
    chk("bnd_dst_high", int'(lock_water >= 254), 1);
    chk("bnd_no_fault", int'(fault), 0);
    @(negedge clk);

    // reset while raising in EQ_DST
    inner_water = 8'd200;
    outer_water = 8'd10;
    lock_water  = 8'd10;
    req_arrive  = 1'b1;
    @(negedge clk);
    req_arrive  = 1'b0;
    found = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd[6]) n++;
      if (n > 0 && cmd[2]) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid_found_raise", int'(found), 1);
    pulse_rst();
    chk("rst_mid_cmd", int'(cmd), 0);
    chk("rst_mid_busy", int'(busy), 0);
    req_arrive = 1'b1;
    @(negedge clk);
    req_arrive = 1'b0;
    chk("restart_busy", int'(busy), 1);
    chk("restart_eq_src", int'(cmd[6:3]), 0);
    run_transit(300, ok);
    chk("restart_completes", int'(ok), 1);
    @(negedge clk);

    // sensor never asserts: phase timeout
    env_auto = 0;
    gondola_in_lock = 1'b0;
    inner_water = 8'd20;
    outer_water = 8'd10;
    lock_water  = 8'd10;
    req_arrive  = 1'b1;
    @(negedge clk);
    req_arrive  = 1'b0;
    n = 0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd[6]) n++;
      if (fault) begin
        found = 1;
        break;
      end
    end
    chk("to_fault_seen", int'(found), 1);
    chk("to_wait_cycles", n, TMO);
    chk("to_cmd", int'(cmd), 0);
    chk("to_busy", int'(busy), 0);
    busy_seen = 0;
    req_arrive = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      busy_seen += int'(busy);
    end
    req_arrive = 1'b0;
    chk("to_req_ignored", busy_seen, 0);
    chk("to_sticky", int'(fault), 1);
    pulse_rst();
    chk("to_rst_fault", int'(fault), 0);
    chk("to_rst_busy", int'(busy), 0);
    chk("to_rst_cmd", int'(cmd), 0);
    env_auto = 1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req_arrive = ($urandom_range(0, 3) == 0);
      req_depart = ($urandom_range(0, 3) == 0);
      if (!busy && cmd == 7'd0 && $urandom_range(0, 3) == 0) begin
        inner_water = 8'($urandom_range(0, 255));
        outer_water = 8'($urandom_range(0, 255));
        lock_water  = 8'($urandom_range(0, 255));
        enter_dly   = $urandom_range(1, 8);
        exit_dly    = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 39) == 0)
        inner_water = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0)
        outer_water = 8'($urandom_range(0, 255));
      if (fault || $urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    rst = 1'b0;
    req_arrive = 1'b0;
    req_depart = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
